// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared decode constants, forwarding-select encoding and opcode class
// helpers for the 5-stage RV32I hazard controller (pipeline_hazard_ctrl).
package hazard_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    // E-stage operand source: register file, W result or M result.
    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_W  = 2'd1,
        FWD_M  = 2'd2
    } fwd_sel_t;

    // Instruction consumes its rs2 field as a register operand.
    function automatic logic reads_rs2(input logic [6:0] op);
        logic r;
        case (op)
            OP_RTYPE, OP_BRANCH, OP_STORE: r = 1'b1;
            default:                       r = 1'b0;
        endcase
        return r;
    endfunction

    // Instruction produces a register-file result (everything but branch/store).
    function automatic logic writes_rd(input logic [6:0] op);
        logic r;
        case (op)
            OP_BRANCH, OP_STORE: r = 1'b0;
            default:             r = 1'b1;
        endcase
        return r;
    endfunction

    // Instruction redirects the fetch stream.
    function automatic logic is_ctrl(input logic [6:0] op);
        logic r;
        case (op)
            OP_BRANCH, OP_JAL, OP_JALR: r = 1'b1;
            default:                    r = 1'b0;
        endcase
        return r;
    endfunction

    // Instruction is a data-memory load.
    function automatic logic is_load(input logic [6:0] op);
        return (op == OP_LOAD);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_raw_match.sv
// raw_match: compares one producer (rd, valid) against a consumer's rs1/rs2.
// x0 is hard-wired zero, so a zero rd never produces a hit.
module raw_match #(
    parameter int AW = 5
) (
    input  logic [AW-1:0] rd_i,
    input  logic          valid_i,
    input  logic [AW-1:0] rs1_i,
    input  logic [AW-1:0] rs2_i,
    output logic          hit_rs1_o,
    output logic          hit_rs2_o
);
    import hazard_pkg::*;

    logic rd_live_s;

    assign rd_live_s = valid_i & (rd_i != '0);
    assign hit_rs1_o = rd_live_s & (rs1_i == rd_i);
    assign hit_rs2_o = rd_live_s & (rs2_i == rd_i);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use / control-transfer hazard controller with
// memory-busy freeze and E-stage forwarding selects.
// Build option HAZARD_FWD_EN: when defined, forwarding is active and only
// load-use stalls; when undefined, forwarding selects are tied to the
// register file and any RAW match against E/M/W interlocks.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int LOAD_LAT  = 1,
    parameter int BR_SHADOW = 2,
    parameter int REG_AW    = 5
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              run,
    input  logic [31:0]       irD,
    input  logic [31:0]       irE,
    input  logic [REG_AW-1:0] rdM,
    input  logic              regWriteM,
    input  logic [REG_AW-1:0] rdW,
    input  logic              regWriteW,
    input  logic              memBusy,
    output logic              fStall,
    output logic              dStall,
    output logic              eFlush,
    output logic [1:0]        fwdA,
    output logic [1:0]        fwdB,
    output logic              shadow
);

    localparam int CNT_MAX = (LOAD_LAT > BR_SHADOW) ? LOAD_LAT : BR_SHADOW;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Field decode
    logic [6:0]        op_d_s, op_e_s;
    logic [REG_AW-1:0] rs1_d_s, rs2_d_s, rs1_e_s, rs2_e_s, rd_e_s;
    logic              rs2_rd_d_s;
    logic              e_valid_s;
    logic [REG_AW-1:0] cmp_rs1_s, cmp_rs2_s;

    assign op_d_s     = irD[6:0];
    assign op_e_s     = irE[6:0];
    assign rs1_d_s    = REG_AW'(irD[19:15]);
    assign rs2_d_s    = REG_AW'(irD[24:20]);
    assign rs1_e_s    = REG_AW'(irE[19:15]);
    assign rs2_e_s    = REG_AW'(irE[24:20]);
    assign rd_e_s     = REG_AW'(irE[11:7]);
    assign rs2_rd_d_s = reads_rs2(op_d_s);

`ifdef HAZARD_FWD_EN
    // E only matters to D as a load; M/W are checked against E's sources.
    assign e_valid_s = is_load(op_e_s);
    assign cmp_rs1_s = rs1_e_s;
    assign cmp_rs2_s = rs2_e_s;
`else
    // Without forwarding every in-flight writer interlocks D's sources.
    assign e_valid_s = writes_rd(op_e_s);
    assign cmp_rs1_s = rs1_d_s;
    assign cmp_rs2_s = rs2_d_s;
`endif

    // Fields not used by any hazard rule in this build.
    logic unused_fields_s;
`ifdef HAZARD_FWD_EN
    assign unused_fields_s = ^{irD[31:25], irD[14:7], irE[31:25], irE[14:12]};
`else
    assign unused_fields_s = ^{irD[31:25], irD[14:7], irE[31:15], irE[14:12]};
`endif

    logic e_hit1_s, e_hit2_s, m_hit1_s, m_hit2_s, w_hit1_s, w_hit2_s;

    raw_match #(.AW(REG_AW)) u_match_e (
        .rd_i      (rd_e_s),
        .valid_i   (e_valid_s),
        .rs1_i     (rs1_d_s),
        .rs2_i     (rs2_d_s),
        .hit_rs1_o (e_hit1_s),
        .hit_rs2_o (e_hit2_s)
    );

    raw_match #(.AW(REG_AW)) u_match_m (
        .rd_i      (rdM),
        .valid_i   (regWriteM),
        .rs1_i     (cmp_rs1_s),
        .rs2_i     (cmp_rs2_s),
        .hit_rs1_o (m_hit1_s),
        .hit_rs2_o (m_hit2_s)
    );

    raw_match #(.AW(REG_AW)) u_match_w (
        .rd_i      (rdW),
        .valid_i   (regWriteW),
        .rs1_i     (cmp_rs1_s),
        .rs2_i     (cmp_rs2_s),
        .hit_rs1_o (w_hit1_s),
        .hit_rs2_o (w_hit2_s)
    );

    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic             bubble_s;
    logic             jump_s;
    logic             advance_s;
    fwd_sel_t         fwd_a_s, fwd_b_s;

    // Counters only move when the pipeline is running and not frozen.
    assign advance_s = run & ~memBusy;

`ifdef HAZARD_FWD_EN
    logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
    logic             detect_s;

    assign detect_s = e_hit1_s | (e_hit2_s & rs2_rd_d_s);
    assign bubble_s = detect_s | (lu_cnt_q != '0);

    // Load-use bubble counter: reload on a fresh detect, else count down to 0.
    always_comb begin
        lu_cnt_d = lu_cnt_q;
        if (!advance_s) begin
            lu_cnt_d = lu_cnt_q;
        end else if (detect_s) begin
            lu_cnt_d = CNT_W'(LOAD_LAT - 1);
        end else if (lu_cnt_q != '0) begin
            lu_cnt_d = lu_cnt_q - CNT_W'(1);
        end else begin
            lu_cnt_d = lu_cnt_q;
        end
    end

    // Load-use counter register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lu_cnt_q <= '0;
        end else begin
            lu_cnt_q <= lu_cnt_d;
        end
    end
`else
    assign bubble_s = e_hit1_s | (e_hit2_s & rs2_rd_d_s)
                    | m_hit1_s | (m_hit2_s & rs2_rd_d_s)
                    | w_hit1_s | (w_hit2_s & rs2_rd_d_s);
`endif

    // A control transfer in D is only acted on once the bubble is gone and no
    // earlier shadow is pending (D is stale during the shadow).
    assign jump_s = is_ctrl(op_d_s) & ~bubble_s & (br_cnt_q == '0) & run;

    // Branch-shadow counter: load on jump, else count down to 0.
    always_comb begin
        br_cnt_d = br_cnt_q;
        if (!advance_s) begin
            br_cnt_d = br_cnt_q;
        end else if (jump_s) begin
            br_cnt_d = CNT_W'(BR_SHADOW);
        end else if (br_cnt_q != '0) begin
            br_cnt_d = br_cnt_q - CNT_W'(1);
        end else begin
            br_cnt_d = br_cnt_q;
        end
    end

    // Branch-shadow counter register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            br_cnt_q <= '0;
        end else begin
            br_cnt_q <= br_cnt_d;
        end
    end

    // Forwarding selects: M result is newer than W, so it wins.
    always_comb begin
        fwd_a_s = FWD_RF;
        fwd_b_s = FWD_RF;
`ifdef HAZARD_FWD_EN
        if (m_hit1_s) begin
            fwd_a_s = FWD_M;
        end else if (w_hit1_s) begin
            fwd_a_s = FWD_W;
        end else begin
            fwd_a_s = FWD_RF;
        end
        if (m_hit2_s) begin
            fwd_b_s = FWD_M;
        end else if (w_hit2_s) begin
            fwd_b_s = FWD_W;
        end else begin
            fwd_b_s = FWD_RF;
        end
`endif
    end

    // Output resolution in priority order: reset, run, freeze, hazards.
    always_comb begin
        fStall = 1'b0;
        dStall = 1'b0;
        eFlush = 1'b0;
        fwdA   = 2'b00;
        fwdB   = 2'b00;
        shadow = 1'b0;
        if (!rstn) begin
            fStall = 1'b0;
            dStall = 1'b0;
            eFlush = 1'b0;
        end else begin
            shadow = (br_cnt_q != '0);
            fwdA   = fwd_a_s;
            fwdB   = fwd_b_s;
            if (!run) begin
                fStall = 1'b0;
                dStall = 1'b0;
                eFlush = 1'b0;
            end else if (memBusy) begin
                fStall = 1'b1;
                dStall = 1'b1;
                eFlush = 1'b0;
            end else begin
                fStall = bubble_s | jump_s;
                dStall = bubble_s | jump_s | (br_cnt_q > CNT_W'(1));
                eFlush = bubble_s | (br_cnt_q != '0);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl. Two instances run side by
// side (LOAD_LAT/BR_SHADOW = 1/2 and 3/3) against a behavioural model that
// follows the HAZARD_FWD_EN build option the same way the design does.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        run = 1'b1;
    logic [31:0] irD = 32'h0000_0013;
    logic [31:0] irE = 32'h0000_0013;
    logic [4:0]  rdM = 5'd0;
    logic        regWriteM = 1'b0;
    logic [4:0]  rdW = 5'd0;
    logic        regWriteW = 1'b0;
    logic        memBusy = 1'b0;

    logic f1, d1, e1, s1, f3, d3, e3, s3;
    logic [1:0] a1, b1, a3, b3;

    pipeline_hazard_ctrl #(.LOAD_LAT(1), .BR_SHADOW(2), .REG_AW(5)) dut1 (
        .clk(clk), .rstn(rstn), .run(run), .irD(irD), .irE(irE),
        .rdM(rdM), .regWriteM(regWriteM), .rdW(rdW), .regWriteW(regWriteW),
        .memBusy(memBusy), .fStall(f1), .dStall(d1), .eFlush(e1),
        .fwdA(a1), .fwdB(b1), .shadow(s1)
    );

    pipeline_hazard_ctrl #(.LOAD_LAT(3), .BR_SHADOW(3), .REG_AW(5)) dut3 (
        .clk(clk), .rstn(rstn), .run(run), .irD(irD), .irE(irE),
        .rdM(rdM), .regWriteM(regWriteM), .rdW(rdW), .regWriteW(regWriteW),
        .memBusy(memBusy), .fStall(f3), .dStall(d3), .eFlush(e3),
        .fwdA(a3), .fwdB(b3), .shadow(s3)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] LW_X5   = {12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011};
    localparam logic [31:0] ADD_651 = {7'd0, 5'd1, 5'd5, 3'b000, 5'd6, 7'b0110011};
    localparam logic [31:0] BEQ_12  = {7'd0, 5'd2, 5'd1, 3'b000, 5'd0, 7'b1100011};
    localparam logic [31:0] JAL_X1  = {20'd0, 5'd1, 7'b1101111};

    int lat_p [2] = '{1, 3};
    int shd_p [2] = '{2, 3};
    int lu_left [2] = '{0, 0};
    int br_left [2] = '{0, 0};
    bit det_m [2];
    bit jmp_m [2];
    int ef [2], ed [2], ee [2], es [2], ea [2], eb [2];

    function automatic bit m_rs2r(input logic [6:0] op);
        return (op == 7'b0110011) || (op == 7'b1100011) || (op == 7'b0100011);
    endfunction
    function automatic bit m_ctrl(input logic [6:0] op);
        return (op == 7'b1100011) || (op == 7'b1101111) || (op == 7'b1100111);
    endfunction
    function automatic bit m_wr(input logic [6:0] op);
        return !((op == 7'b1100011) || (op == 7'b0100011));
    endfunction
    function automatic bit src_hit(input logic [4:0] rd, input bit vld,
                                   input logic [4:0] a, input logic [4:0] b, input bit use_b);
        return vld && (rd != 5'd0) && ((rd == a) || (use_b && (rd == b)));
    endfunction
    function automatic int fwd_sel(input logic [4:0] rs);
`ifdef HAZARD_FWD_EN
        if (regWriteM && rdM != 5'd0 && rdM == rs) return 2;
        if (regWriteW && rdW != 5'd0 && rdW == rs) return 1;
`endif
        return 0;
    endfunction

    // Compare process: expected values from the model, sampled mid-cycle.
    always @(negedge clk) begin
        logic [6:0] opd, ope;
        logic [4:0] rs1d, rs2d, rde;
        bit bub;
        bit [1:0] fv, dv, ev, sv;
        logic [1:0] av [2];
        logic [1:0] bv [2];
        opd = irD[6:0]; ope = irE[6:0];
        rs1d = irD[19:15]; rs2d = irD[24:20]; rde = irE[11:7];
        fv = {f3, f1}; dv = {d3, d1}; ev = {e3, e1}; sv = {s3, s1};
        av[0] = a1; av[1] = a3; bv[0] = b1; bv[1] = b3;
        for (int k = 0; k < 2; k++) begin
`ifdef HAZARD_FWD_EN
            det_m[k] = src_hit(rde, ope == 7'b0000011, rs1d, rs2d, m_rs2r(opd));
            bub = det_m[k] || (lu_left[k] != 0);
`else
            det_m[k] = 1'b0;
            bub = src_hit(rde, m_wr(ope), rs1d, rs2d, m_rs2r(opd))
               || src_hit(rdM, regWriteM, rs1d, rs2d, m_rs2r(opd))
               || src_hit(rdW, regWriteW, rs1d, rs2d, m_rs2r(opd));
`endif
            jmp_m[k] = m_ctrl(opd) && !bub && (br_left[k] == 0) && run;
            if (!rstn) begin
                ef[k] = 0; ed[k] = 0; ee[k] = 0; es[k] = 0; ea[k] = 0; eb[k] = 0;
            end else begin
                es[k] = (br_left[k] != 0);
                ea[k] = fwd_sel(irE[19:15]);
                eb[k] = fwd_sel(irE[24:20]);
                if (!run) begin
                    ef[k] = 0; ed[k] = 0; ee[k] = 0;
                end else if (memBusy) begin
                    ef[k] = 1; ed[k] = 1; ee[k] = 0;
                end else begin
                    ef[k] = bub || jmp_m[k];
                    ed[k] = bub || jmp_m[k] || (br_left[k] > 1);
                    ee[k] = bub || (br_left[k] != 0);
                end
            end
            check($sformatf("fStall[L%0d]", lat_p[k]), fv[k], ef[k]);
            check($sformatf("dStall[L%0d]", lat_p[k]), dv[k], ed[k]);
            check($sformatf("eFlush[L%0d]", lat_p[k]), ev[k], ee[k]);
            check($sformatf("shadow[L%0d]", lat_p[k]), sv[k], es[k]);
            check($sformatf("fwdA[L%0d]", lat_p[k]), av[k], ea[k]);
            check($sformatf("fwdB[L%0d]", lat_p[k]), bv[k], eb[k]);
        end
    end

    // Model state advance: remaining bubble and shadow cycles.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rstn) begin
                lu_left[k] <= 0;
                br_left[k] <= 0;
            end else if (run && !memBusy) begin
                lu_left[k] <= det_m[k] ? lat_p[k] - 1 : (lu_left[k] > 0 ? lu_left[k] - 1 : 0);
                br_left[k] <= jmp_m[k] ? shd_p[k] : (br_left[k] > 0 ? br_left[k] - 1 : 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic probe();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [8];
        logic [31:0] w;
        ops[0] = 7'b0000011; ops[1] = 7'b1100011; ops[2] = 7'b1101111; ops[3] = 7'b1100111;
        ops[4] = 7'b0110011; ops[5] = 7'b0100011; ops[6] = 7'b0010011; ops[7] = 7'b0110111;
        w = $urandom;
        w[6:0]   = ops[$urandom_range(0, 7)];
        w[11:7]  = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        return w;
    endfunction

    initial begin
        int exp_fwd;
`ifdef HAZARD_FWD_EN
        exp_fwd = 2;
`else
        exp_fwd = 0;
`endif
        // Reset held with a branch in D: everything must read zero.
        irD = BEQ_12; irE = LW_X5; rdM = 5'd5; regWriteM = 1'b1;
        probe();
        check("rst_fStall", f1, 0); check("rst_dStall", d1, 0);
        check("rst_eFlush", e1, 0); check("rst_fwdA", a1, 0);
        check("rst_shadow", s1, 0);

        // Load-use: lw x5 in E, add x6,x5,x1 in D.
        step();
        rstn = 1'b1; irD = ADD_651; irE = LW_X5; rdM = 5'd0; regWriteM = 1'b0;
        probe();
        check("lu_fStall", f1, 1); check("lu_dStall", d1, 1);
        check("lu_eFlush", e1, 1); check("lu_model_f", ef[0], 1);

        // Pair advances; M and W both write x5, M must win the forward.
        step();
        irE = ADD_651; irD = NOP; rdM = 5'd5; regWriteM = 1'b1; rdW = 5'd5; regWriteW = 1'b1;
        probe();
        check("lu_after_fStall", f1, 0); check("lu_after_eFlush", e1, 0);
        check("fwd_prio_fwdA", a1, exp_fwd); check("fwd_fwdB_x1", b1, 0);

        step();
        irE = NOP; rdM = 5'd0; regWriteM = 1'b0; rdW = 5'd0; regWriteW = 1'b0;
        repeat (3) step();

        // Branch shadow: beq in D.
        irD = BEQ_12;
        probe();
        check("br0_fStall", f1, 1); check("br0_dStall", d1, 1); check("br0_eFlush", e1, 0);
        step();
        probe();
        check("br1_fStall", f1, 0); check("br1_dStall", d1, 1); check("br1_eFlush", e1, 1);
        check("br1_shadow", s1, 1);
        step();
        probe();
        check("br2_dStall", d1, 0); check("br2_eFlush", e1, 1);
        step();
        irD = NOP;
        probe();
        check("br3_eFlush_s2", e1, 0); check("br3_eFlush_s3", e3, 1);
        step();
        probe();
        check("br4_eFlush_s3", e3, 0);

        // Reset asserted in the middle of a shadow.
        step();
        irD = JAL_X1;
        probe();
        check("jal_fStall", f1, 1);
        step();
        irD = NOP; rstn = 1'b0;
        probe();
        check("rstmid_dStall", d1, 0); check("rstmid_eFlush", e1, 0);
        check("rstmid_shadow", s1, 0);
        step();
        rstn = 1'b1;
        probe();
        check("rstrel_eFlush", e1, 0); check("rstrel_shadow", s3, 0);
        check("rstrel_model_s", es[1], 0);

        // Randomised traffic checked every cycle by the compare process.
        for (int i = 0; i < 4000; i++) begin
            step();
            irD       = rand_instr();
            irE       = rand_instr();
            rdM       = 5'($urandom_range(0, 3));
            regWriteM = 1'($urandom_range(0, 1));
            rdW       = 5'($urandom_range(0, 3));
            regWriteW = 1'($urandom_range(0, 1));
            memBusy   = ($urandom_range(0, 9) == 0);
            run       = ($urandom_range(0, 19) != 0);
            rstn      = ($urandom_range(0, 199) != 0);
        end
        step();
        probe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Parametrised hazard controller for the 5-stage RV32I pipeline (F/D/E/M/W). It generalises load-use and control-transfer handling to a configurable load latency and a configurable branch-shadow length. It honours a multi-cycle data-memory busy freeze and produces E-stage operand forwarding selects. It sits beside the pipeline registers and drives their stall and flush enables.

## Interface
- `LOAD_LAT`, default 1: bubble cycles inserted per load-use hazard; legal range ≥1.
- `BR_SHADOW`, default 2: cycles after a control transfer during which E is flushed; legal range ≥1.
- `REG_AW`, default 5: register address width.
- `clk` in 1: pipeline clock.
- `rstn` in 1: reset. Asynchronous, active-low.
- `run` in 1: pipeline enable. 0 forces all hazard outputs low.
- `irD` in 32: instruction in D.
- `irE` in 32: instruction in E.
- `rdM` in REG_AW: destination register in M.
- `regWriteM` in 1: M instruction writes the register file.
- `rdW` in REG_AW: destination register in W.
- `regWriteW` in 1: W instruction writes the register file.
- `memBusy` in 1: data memory not ready; freezes the pipeline.
- `fStall` out 1: hold PC and the F/D register.
- `dStall` out 1: hold the D/E source; suppress D advance.
- `eFlush` out 1: load a bubble into E.
- `fwdA` out 2: rs1 select for E. 0 = regfile, 1 = W, 2 = M.
- `fwdB` out 2: rs2 select for E, same encoding as `fwdA`.
- `shadow` out 1: branch-shadow counter nonzero.

## Operation
- Opcode classes:
  - rs2 readers: 0110011 (R-type), 1100011 (branch), 0100011 (store).
  - Load: 0000011.
  - Control transfer: 1100011, 1101111 (jal), 1100111 (jalr).
  - Writers: all opcodes except branch and store.
- Load-use detect:
  - Condition: `irE` is a load, rd(E) ≠ 0, and rd(E) equals rs1(D), or equals rs2(D) when D is an rs2 reader.
  - On detect, `luCnt` loads LOAD_LAT−1.
  - `bubble` = detect OR `luCnt` ≠ 0.
  - `luCnt` decrements each non-frozen cycle while nonzero.
- Control transfer:
  - `jump` = D opcode is a control transfer AND NOT `bubble` AND `brCnt` = 0 AND `run`.
  - On `jump`, `brCnt` loads BR_SHADOW. It decrements each non-frozen cycle while nonzero.
- Output equations (unfrozen, `run`=1):
  - `fStall` = `bubble` | `jump`.
  - `dStall` = `bubble` | `jump` | (`brCnt` > 1).
  - `eFlush` = `bubble` | (`brCnt` ≠ 0).
  - With BR_SHADOW=2 this gives the legacy 1-cycle stall plus 2-cycle flush pattern.
- Freeze: `memBusy`=1 forces `fStall`=`dStall`=1 and `eFlush`=0. Both counters hold. Hazard detects are not latched.
- `run`=0: `fStall`, `dStall`, `eFlush` = 0. Counters hold.
- Priority: reset > `run`=0 > freeze > load-use > control transfer. A jump coinciding with a load-use bubble is taken after the bubble clears. A control transfer in D while `brCnt` ≠ 0 is ignored, because D is stale.
- Forwarding (E stage):
  - rs1(E) and rs2(E) are compared against rdM when `regWriteM`, and against rdW when `regWriteW`. Register x0 never matches.
  - M has priority over W.

## Timing
- Hazard outputs are combinational from inputs and counter state, valid in the same cycle.
- Counters update on `posedge clk`.
- A load-use hazard produces exactly LOAD_LAT consecutive bubble cycles, excluding frozen cycles.
- A jump produces one stall cycle, then BR_SHADOW flush cycles. `dStall` is asserted for the first BR_SHADOW−1 of those flush cycles.
- Counter width is $clog2(max(LOAD_LAT, BR_SHADOW)+1). Counters saturate at 0 and never wrap.
- Reset (`rstn`=0):
  - Counters are cleared asynchronously.
  - All outputs are forced to 0 while reset is held, including `fwdA`, `fwdB` and `shadow`.
  - Reset asserted mid-shadow or mid-bubble abandons the sequence. No residual stall follows reset release.

## Configuration
- `HAZARD_FWD_EN` defined:
  - Forwarding logic as above.
  - Load-use is the only data stall.
- `HAZARD_FWD_EN` undefined:
  - `fwdA` and `fwdB` are tied to 0. `luCnt` is removed.
  - `bubble` = D source matches a nonzero rd of E (writer class), M (`regWriteM`) or W (`regWriteW`).
  - The regfile is not write-through, so W matches stall.
  - The interlock persists until no match remains.

## Structure
- `hazard_pkg` holds:
  - Opcode constants (OP_LOAD, OP_BRANCH, OP_JAL, OP_JALR, OP_RTYPE, OP_STORE).
  - The `fwd_sel_t` enum: FWD_RF=0, FWD_W=1, FWD_M=2.
  - Class-decode functions (`reads_rs2`, `writes_rd`, `is_ctrl`).
- Sub-module `raw_match`: combinational compare of one rd/valid pair against rs1/rs2 with the x0 guard. It is instantiated per producer stage.

## Test plan
- **Load-use:** LOAD_LAT=1, E=`lw x5`, D=`add x6,x5,x1` → one cycle of `fStall`=`dStall`=`eFlush`=1. Next cycle all 0 and `fwdA`=2.
- **Load-use, longer latency:** LOAD_LAT=3, same pair → exactly 3 bubble cycles. With `memBusy` pulsed 2 cycles mid-sequence → 5 total stalled cycles, `eFlush` low during the freeze.
- **Branch shadow:** BR_SHADOW=2, D=`beq` → cycle 0: `fStall`=`dStall`=1. Cycle 1: `dStall`=`eFlush`=1. Cycle 2: `eFlush`=1 only. With BR_SHADOW=3 → `eFlush` for 3 cycles.
- **Jump behind load-use:** E=`lw x2`, D=`jalr x0,0(x2)` → 1 bubble, then the jump sequence starts on the following cycle. A `jal` in D during the shadow is ignored.
- **Forwarding priority and reset:** rdM=rdW=x7, both regWrite, E reads x7 → `fwdA`=2. rd=x0 → `fwdA`=0. `rstn` low mid-shadow → all outputs 0 immediately, no stall after release.
- **No-forwarding build:** `HAZARD_FWD_EN` undefined, `addi x3` in M, D=`add x4,x3,x3` → stall for 2 cycles (M, then W), `fwdA`=`fwdB`=0 throughout.
